ddr5_phy_crc_burst: RTL

- Parametrised write-CRC engine for the DDR5 PHY write path. Sits between the write data block and the DQ serializer.
- Accumulates one CRC-8 per DQ nibble over a BL16 (or BC8) burst, then appends one extra clock carrying UI16/UI17 CRC bits. Write bursts leave as BL18.
- Handles burst framing, BC8 padding, gaps in valid, and CRC bypass. The previous generation was a free-running per-byte CRC with no framing.

---
 rtl/ddr5_phy_crc_pkg.sv | 44 ++++
 rtl/ddr5_phy_crc8_nibble.sv | 41 ++++
 rtl/ddr5_phy_crc_burst.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ddr5_phy_crc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr5_phy_crc_pkg
// Purpose : Shared types, constants and CRC-8 helpers for the DDR5 write-CRC
//           engine.
// Revision: 1.0 - initial release
// ============================================================================
package ddr5_phy_crc_pkg;

  localparam logic [7:0] CRC_POLY       = 8'h07;
  localparam int         CRC_W          = 8;
  localparam int         LANES_PER_GRP  = 4;
  localparam int         PAD_MAX_CHUNKS = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } crc_state_e;

  // Folds one clock of one group: even-UI lanes (bits 3:0) then odd-UI lanes.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic [CRC_W-1:0] chunk);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < CRC_W; i++) begin
      if (c[CRC_W-1] ^ chunk[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
      else                       c = {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] crc8_pad_ones(input logic [CRC_W-1:0] crc,
                                                     input int n_chunks);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < PAD_MAX_CHUNKS; i++) begin
      if (i < n_chunks) c = crc8_step(c, 8'hFF);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr5_phy_crc8_nibble.sv
`default_nettype none
// ============================================================================
// Module  : ddr5_phy_crc8_nibble
// Purpose : CRC-8 accumulator for one 4-lane DQ group, with optional BC8
//           all-ones padding applied on the output.
// Revision: 1.0 - initial release
// ============================================================================
module ddr5_phy_crc8_nibble
  import ddr5_phy_crc_pkg::*;
#(
  parameter int pPAD_CHUNKS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             fold_i,
  input  logic             pad_i,
  input  logic [CRC_W-1:0] data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CRC_W-1:0] w_seed;

  // A clear restarts from init on the same beat that is folded in.
  always_comb begin
    w_seed = clr_i ? '0 : crc_q;
    crc_d  = crc_q;
    if (fold_i) crc_d = crc8_step(w_seed, data_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o = pad_i ? crc8_pad_ones(crc_q, pPAD_CHUNKS) : crc_q;

endmodule
`default_nettype wire

// File: rtl/ddr5_phy_crc_burst.sv
`default_nettype none
// ============================================================================
// Module  : ddr5_phy_crc_burst
// Purpose : Write-CRC engine: frames BL16/BC8 bursts, echoes data one cycle
//           later and appends a UI16/UI17 CRC beat (bursts leave as BL18).
//           Optional macro DDR5_PHY_CRC_ERR_INJECT_EN adds err_inject_i.
// Revision: 1.0 - initial release
// ============================================================================
module ddr5_phy_crc_burst
  import ddr5_phy_crc_pkg::*;
#(
  parameter int pDRAM_SIZE = 4,
  parameter int pBURST_LEN = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    crc_en_i,
  input  logic                    bc8_i,
  input  logic                    wr_valid_i,
  input  logic                    wr_first_i,
`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
  input  logic                    err_inject_i,
`endif
  input  logic [2*pDRAM_SIZE-1:0] wr_data_i,
  output logic                    wr_ready_o,
  output logic [2*pDRAM_SIZE-1:0] dq_o,
  output logic                    dq_valid_o,
  output logic                    crc_beat_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int NGRP       = pDRAM_SIZE / LANES_PER_GRP;
  localparam int BEATS_FULL = pBURST_LEN / 2;
  localparam int BEATS_BC8  = pBURST_LEN / 4;
  // Pad is pBURST_LEN/2 UI, i.e. pBURST_LEN/4 clocks of 8 bits per group.
  localparam int PAD_CHUNKS = pBURST_LEN / 4;
  localparam int CNT_W      = $clog2(BEATS_FULL + 1);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(BEATS_FULL);
  localparam logic [CNT_W-1:0] LAST_BC8  = CNT_W'(BEATS_BC8);

  crc_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      crc_en_q, crc_en_d;
  logic                      bc8_q, bc8_d;
  logic                      err_q, err_d;
  logic [2*pDRAM_SIZE-1:0]   dq_q, dq_d;
  logic                      dq_valid_q, dq_valid_d;
  logic                      crc_beat_q, crc_beat_d;

  logic                      w_accept;
  logic                      w_clr;
  logic                      w_fold;
  logic                      w_inj;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic [CNT_W-1:0]          w_last_cnt;
  logic [2*pDRAM_SIZE-1:0]   w_crc_beat;

`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
  logic inj_q, inj_d;
  assign w_inj = inj_q;
`else
  assign w_inj = 1'b0;
`endif

  assign wr_ready_o = (state_q != CRC);
  assign busy_o     = (state_q != IDLE);
  assign w_accept   = wr_valid_i && wr_ready_o;
  assign w_cnt_inc  = cnt_q + 1'b1;
  assign w_last_cnt = bc8_q ? LAST_BC8 : LAST_FULL;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    logic [CRC_W-1:0] w_crc;
    logic [CRC_W-1:0] w_crc_out;

    ddr5_phy_crc8_nibble #(
      .pPAD_CHUNKS (PAD_CHUNKS)
    ) u_crc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (w_clr),
      .fold_i (w_fold),
      .pad_i  (bc8_q),
      .data_i ({wr_data_i[pDRAM_SIZE + LANES_PER_GRP*g +: LANES_PER_GRP],
                wr_data_i[LANES_PER_GRP*g +: LANES_PER_GRP]}),
      .crc_o  (w_crc)
    );

    assign w_crc_out = (g == 0) ? (w_crc ^ {7'd0, w_inj}) : w_crc;
    assign w_crc_beat[LANES_PER_GRP*g +: LANES_PER_GRP]              = w_crc_out[3:0];
    assign w_crc_beat[pDRAM_SIZE + LANES_PER_GRP*g +: LANES_PER_GRP] = w_crc_out[7:4];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_en_d   = crc_en_q;
    bc8_d      = bc8_q;
    err_d      = err_q;
    dq_d       = dq_q;
    dq_valid_d = 1'b0;
    crc_beat_d = 1'b0;
    w_clr      = 1'b0;
    w_fold     = 1'b0;
`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
    inj_d      = inj_q;
`endif

    // Any accepted beat is echoed unchanged, including error beats.
    if (w_accept) begin
      dq_d       = wr_data_i;
      dq_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (wr_first_i) begin
            crc_en_d = crc_en_i;
            bc8_d    = bc8_i;
`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
            inj_d    = err_inject_i;
`endif
            w_clr    = 1'b1;
            w_fold   = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          w_fold = 1'b1;
          if (wr_first_i) begin
            // Abandon the open burst and restart with this beat as beat 1.
            err_d    = 1'b1;
            crc_en_d = crc_en_i;
            bc8_d    = bc8_i;
`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
            inj_d    = err_inject_i;
`endif
            w_clr    = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if (w_cnt_inc == w_last_cnt) begin
            cnt_d   = '0;
            state_d = crc_en_q ? CRC : IDLE;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end
      end
      CRC: begin
        dq_d       = w_crc_beat;
        dq_valid_d = 1'b1;
        crc_beat_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      crc_en_q   <= 1'b0;
      bc8_q      <= 1'b0;
      err_q      <= 1'b0;
      dq_q       <= '0;
      dq_valid_q <= 1'b0;
      crc_beat_q <= 1'b0;
`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
      inj_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_en_q   <= crc_en_d;
      bc8_q      <= bc8_d;
      err_q      <= err_d;
      dq_q       <= dq_d;
      dq_valid_q <= dq_valid_d;
      crc_beat_q <= crc_beat_d;
`ifdef DDR5_PHY_CRC_ERR_INJECT_EN
      inj_q      <= inj_d;
`endif
    end
  end

  assign dq_o       = dq_q;
  assign dq_valid_o = dq_valid_q;
  assign crc_beat_o = crc_beat_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire
